// File: rtl/aplic_domain_pkg.sv
// rtl/aplic_domain_pkg.sv - shared types for APLIC domain MSI delivery
package aplic_domain_pkg;

    localparam int NrDomainsMax  = 16;
    localparam int DomIdxW       = $clog2(NrDomainsMax);
    // Each hart owns one 4 KiB interrupt file page above the domain base.
    localparam int MsiHartStride = 12;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    typedef enum logic [1:0] {
        MsiIdle = StIdle,
        MsiSend = StSend,
        MsiResp = StResp
    } msi_arb_state_e;

    typedef struct packed {
        logic [31:0] Addr;
    } domain_cfg_t;

    typedef struct packed {
        logic [31:0]        addr;
        logic [31:0]        data;
        logic [DomIdxW-1:0] dom;
    } msi_req_t;

endpackage

// File: rtl/aplic_rr_arbiter.sv
// rtl/aplic_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module aplic_rr_arbiter #(
    parameter int N = 2,
    localparam int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grantIdx,
    output logic            anyGrant
);

    logic [IdxW-1:0] cand;

    // Walk requesters from ptr upward (wrapping) and take the first one set.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = IdxW'((int'(ptr) + i) % N);
            if (!anyGrant && req[cand]) begin
                anyGrant    = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = cand;
            end
        end
    end

endmodule

// File: rtl/aplic_domain_msi_arb.sv
// rtl/aplic_domain_msi_arb.sv - shares one MSI write port among APLIC domains
module aplic_domain_msi_arb
    import aplic_domain_pkg::*;
#(
    parameter int NrDomains = 2,
    parameter int HartIdxW  = 4,
    parameter int EiidW     = 11,
    localparam int DomW     = $clog2(NrDomains)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  domain_cfg_t [NrDomains-1:0]        domain_cfg_i,
    input  logic [NrDomains-1:0]               req_valid_i,
    output logic [NrDomains-1:0]               req_ready_o,
    input  logic [NrDomains-1:0][HartIdxW-1:0] req_hart_i,
    input  logic [NrDomains-1:0][EiidW-1:0]    req_eiid_i,
    output logic                               msi_aw_valid_o,
    input  logic                               msi_aw_ready_i,
    output logic [31:0]                        msi_aw_addr_o,
    output logic                               msi_w_valid_o,
    input  logic                               msi_w_ready_i,
    output logic [31:0]                        msi_w_data_o,
    input  logic                               msi_b_valid_i,
    output logic                               msi_b_ready_o,
    input  logic                               msi_b_err_i,
    output logic                               err_valid_o,
    output logic [DomW-1:0]                    err_domain_o,
    output logic                               busy_o
);

    msi_arb_state_e       state;
    logic [DomW-1:0]      rrPtr;
    msi_req_t             curReq;
    logic                 awPending;
    logic                 wPending;
    logic                 errValid;
    logic [DomW-1:0]      errDomain;

    logic [NrDomains-1:0] arbReq;
    logic [NrDomains-1:0] grant;
    logic [DomW-1:0]      grantIdx;
    logic                 anyGrant;
    logic [31:0]          grantAddr;
    logic [31:0]          grantData;
    logic                 awDoneNow;
    logic                 wDoneNow;

    // Requests are only visible to the arbiter while no write is in flight.
    assign arbReq = (state == MsiIdle) ? req_valid_i : '0;

    aplic_rr_arbiter #(
        .N(NrDomains)
    ) u_rr_arbiter (
        .req      (arbReq),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    // Address arithmetic wraps mod 2^32 on purpose; overflow is not an error.
    assign grantAddr = domain_cfg_i[grantIdx].Addr
                     + (32'(req_hart_i[grantIdx]) << MsiHartStride);
    assign grantData = 32'(req_eiid_i[grantIdx]);

    // A channel counts as done once its valid has dropped or handshakes now.
    assign awDoneNow = !awPending || msi_aw_ready_i;
    assign wDoneNow  = !wPending  || msi_w_ready_i;

    // Grant, issue one AW/W pair, then wait for its B before the next grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= MsiIdle;
            rrPtr     <= '0;
            curReq    <= '0;
            awPending <= 1'b0;
            wPending  <= 1'b0;
            errValid  <= 1'b0;
            errDomain <= '0;
        end else begin
            errValid <= 1'b0;
            unique case (state)
                MsiIdle: begin
                    if (anyGrant) begin
                        rrPtr  <= (grantIdx == DomW'(NrDomains - 1)) ? '0 : grantIdx + 1'b1;
                        curReq <= '{addr: grantAddr, data: grantData, dom: DomIdxW'(grantIdx)};
                        // EIID 0 is "no interrupt": consume it without a write.
                        if (grantData != '0) begin
                            state     <= MsiSend;
                            awPending <= 1'b1;
                            wPending  <= 1'b1;
                        end
                    end
                end
                MsiSend: begin
                    if (msi_aw_ready_i) awPending <= 1'b0;
                    if (msi_w_ready_i)  wPending  <= 1'b0;
                    if (awDoneNow && wDoneNow) state <= MsiResp;
                end
                MsiResp: begin
                    if (msi_b_valid_i) begin
                        state <= MsiIdle;
                        if (msi_b_err_i) begin
                            errValid  <= 1'b1;
                            errDomain <= DomW'(curReq.dom);
                        end
                    end
                end
                default: state <= MsiIdle;
            endcase
        end
    end

    assign req_ready_o    = grant;
    assign msi_aw_valid_o = awPending;
    assign msi_aw_addr_o  = curReq.addr;
    assign msi_w_valid_o  = wPending;
    assign msi_w_data_o   = curReq.data;
    assign msi_b_ready_o  = (state == MsiResp);
    assign err_valid_o    = errValid;
    assign err_domain_o   = errDomain;
    assign busy_o         = (state != MsiIdle);

endmodule

// File: tb/tb_aplic_domain_msi_arb.sv
// tb/tb_aplic_domain_msi_arb.sv - self-checking bench for aplic_domain_msi_arb
module tb_aplic_domain_msi_arb;
    import aplic_domain_pkg::*;

    localparam int N  = 2;
    localparam int HW = 4;
    localparam int EW = 11;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    domain_cfg_t [N-1:0]  cfg;
    logic [N-1:0]         reqValid;
    logic [N-1:0]         reqReady;
    logic [N-1:0][HW-1:0] reqHart;
    logic [N-1:0][EW-1:0] reqEiid;
    logic                 awValid, awReady, wValid, wReady;
    logic [31:0]          awAddr, wData;
    logic                 bValid, bReady, bErr;
    logic                 errValid;
    logic [0:0]           errDomain;
    logic                 busy;

    int checks = 0;
    int failures = 0;
    int mPtr = 0;
    int mErrDom = 0;
    int cycle = 0;
    int pulseCnt = 0;
    int grantCycles[$];

    always #5 clk = ~clk;

    aplic_domain_msi_arb #(.NrDomains(N), .HartIdxW(HW), .EiidW(EW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .domain_cfg_i   (cfg),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_hart_i     (reqHart),
        .req_eiid_i     (reqEiid),
        .msi_aw_valid_o (awValid),
        .msi_aw_ready_i (awReady),
        .msi_aw_addr_o  (awAddr),
        .msi_w_valid_o  (wValid),
        .msi_w_ready_i  (wReady),
        .msi_w_data_o   (wData),
        .msi_b_valid_i  (bValid),
        .msi_b_ready_o  (bReady),
        .msi_b_err_i    (bErr),
        .err_valid_o    (errValid),
        .err_domain_o   (errDomain),
        .busy_o         (busy)
    );

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst_ni && reqReady != '0) begin
            pulseCnt <= pulseCnt + 1;
            grantCycles.push_back(cycle);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the rotation pointer.
    function automatic int modelGrant(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int d = (mPtr + k) % N;
            if (r[d]) return d;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        reqValid = '0; awReady = 0; wReady = 0; bValid = 0; bErr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        mPtr = 0;
        mErrDom = 0;
    endtask

    // One transaction against the model; slave readies arrive after the given delays.
    task automatic doTxn(input int awDelay, input int wDelay, input int bDelay,
                         input bit bErrIn, input bit holdReq,
                         output int g, output logic [31:0] oAddr, output logic [31:0] oData,
                         output bit oAw, output bit oErr);
        logic [31:0] expAddr, expData;
        logic [EW-1:0] eiid;
        bit awDone, wDone, ok;
        #1;
        g = modelGrant(reqValid);
        oAddr = 0; oData = 0; oAw = 0; oErr = 0;
        chk("grant", 32'(reqReady), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g < 0) begin
            step();
            return;
        end
        expAddr = 32'(64'(cfg[g].Addr) + 64'(reqHart[g]) * 64'd4096);
        expData = 32'(reqEiid[g]);
        eiid = reqEiid[g];
        mPtr = (g + 1) % N;
        step();
        if (!holdReq) reqValid = '0;
        #1;
        chk("errPulseOneCycle", 32'(errValid), 0);
        oAw = awValid;
        if (eiid == 0) begin
            chk("eiid0NoAw", 32'(awValid), 0);
            chk("eiid0NoW", 32'(wValid), 0);
            chk("eiid0Idle", 32'(busy), 0);
            return;
        end
        oAddr = awAddr;
        oData = wData;
        chk("awValidFirst", 32'(awValid), 1);
        chk("wValidFirst", 32'(wValid), 1);
        chk("awAddr", awAddr, expAddr);
        chk("wData", wData, expData);
        chk("busySend", 32'(busy), 1);
        awDone = 0; wDone = 0; ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            awReady = (c >= awDelay);
            wReady  = (c >= wDelay);
            // A stray response while writing must be ignored.
            bValid  = (c == 0 && awDelay > 0);
            bErr    = bValid;
            #1;
            chk("awValid", 32'(awValid), 32'(!awDone));
            chk("wValid", 32'(wValid), 32'(!wDone));
            if (!awDone) chk("awAddrStable", awAddr, expAddr);
            if (!wDone) chk("wDataStable", wData, expData);
            chk("bReadyInSend", 32'(bReady), 0);
            chk("noGrantInSend", 32'(reqReady), 0);
            @(posedge clk);
            if (awReady) awDone = 1;
            if (wReady) wDone = 1;
            #1;
            ok = awDone && wDone;
        end
        awReady = 0; wReady = 0; bValid = 0; bErr = 0;
        chk("bothHandshakes", 32'(ok), 1);
        for (int c = 0; c < bDelay; c++) begin
            #1;
            chk("bReadyWait", 32'(bReady), 1);
            chk("busyResp", 32'(busy), 1);
            step();
        end
        bValid = 1; bErr = bErrIn;
        #1;
        chk("bReady", 32'(bReady), 1);
        step();
        bValid = 0; bErr = 0;
        if (bErrIn) mErrDom = g;
        chk("errValid", 32'(errValid), 32'(bErrIn));
        chk("errDomain", 32'(errDomain), mErrDom);
        chk("busyAfterB", 32'(busy), 0);
        oErr = errValid;
    endtask

    typedef struct {
        int          dom;
        logic [31:0] base;
        logic [3:0]  hart;
        logic [10:0] eiid;
        bit          bErr;
        bit          expAw;
        logic [31:0] expAddr;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int expAlt[4];
        int g, p0, q0;
        logic [31:0] a, d;
        bit aw, e;

        cfg = '0; reqValid = '0; reqHart = '0; reqEiid = '0;
        awReady = 0; wReady = 0; bValid = 0; bErr = 0;

        doReset();
        #1;
        chk("rstAwValid", 32'(awValid), 0);
        chk("rstWValid", 32'(wValid), 0);
        chk("rstBReady", 32'(bReady), 0);
        chk("rstErrValid", 32'(errValid), 0);
        chk("rstErrDomain", 32'(errDomain), 0);
        chk("rstBusy", 32'(busy), 0);
        chk("rstReqReady", 32'(reqReady), 0);
        chk("rstAwAddr", awAddr, 0);
        chk("rstWData", wData, 0);
        step();

        tbl[0] = '{0, 32'h2400_0000, 4'd3,  11'd5,     1'b0, 1'b1, 32'h2400_3000, 32'h5,   1'b0};
        tbl[1] = '{1, 32'hFFFF_F000, 4'd1,  11'h7FF,   1'b0, 1'b1, 32'h0000_0000, 32'h7FF, 1'b0};
        tbl[2] = '{1, 32'h1000_0000, 4'd15, 11'd1,     1'b1, 1'b1, 32'h1000_F000, 32'h1,   1'b1};
        tbl[3] = '{0, 32'h0000_0800, 4'd7,  11'h400,   1'b1, 1'b1, 32'h0000_7800, 32'h400, 1'b1};
        tbl[4] = '{0, 32'h2800_0000, 4'd2,  11'd0,     1'b0, 1'b0, 32'h0,         32'h0,   1'b0};

        foreach (tbl[i]) begin
            cfg[tbl[i].dom].Addr = tbl[i].base;
            reqHart[tbl[i].dom]  = tbl[i].hart;
            reqEiid[tbl[i].dom]  = tbl[i].eiid;
            reqValid = '0;
            reqValid[tbl[i].dom] = 1'b1;
            doTxn(0, 0, 0, tbl[i].bErr, 0, g, a, d, aw, e);
            chk("tblGrant", g, tbl[i].dom);
            chk("tblAw", 32'(aw), 32'(tbl[i].expAw));
            if (tbl[i].expAw) begin
                chk("tblAddr", a, tbl[i].expAddr);
                chk("tblData", d, tbl[i].expData);
                chk("tblErr", 32'(e), 32'(tbl[i].expErr));
            end
        end

        // Continuous requests from both domains alternate at 3 cycles per MSI.
        doReset();
        expAlt = '{0, 1, 0, 1};
        cfg[0].Addr = 32'h3000_0000; cfg[1].Addr = 32'h3100_0000;
        reqEiid[0] = 11'd1; reqEiid[1] = 11'd2;
        p0 = pulseCnt;
        q0 = grantCycles.size();
        reqValid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            doTxn(0, 0, 0, 0, 1, g, a, d, aw, e);
            chk("altGrant", g, expAlt[t]);
        end
        reqValid = '0;
        step();
        chk("altPulseCount", pulseCnt - p0, 4);
        for (int i = 1; i < 4; i++)
            chk("altPeriod", grantCycles[q0 + i] - grantCycles[q0 + i - 1], 3);

        // AW stalled 4 cycles while W handshakes immediately.
        reqHart[1] = 4'd2; reqEiid[1] = 11'd3;
        reqValid = 2'b10;
        doTxn(4, 0, 1, 0, 0, g, a, d, aw, e);
        chk("stallGrant", g, 1);
        chk("stallAddr", a, 32'h3100_2000);

        // EIID 0 is consumed silently and still moves the pointer.
        doReset();
        reqEiid[0] = 11'd0;
        reqValid = 2'b01;
        doTxn(0, 0, 0, 0, 0, g, a, d, aw, e);
        chk("eiid0Grant", g, 0);
        reqEiid[0] = 11'd4; reqEiid[1] = 11'd6;
        reqValid = 2'b11;
        doTxn(0, 0, 0, 0, 0, g, a, d, aw, e);
        chk("eiid0PtrAdvanced", g, 1);

        // Asynchronous reset while the write is outstanding.
        step();
        reqEiid[0] = 11'd9;
        reqValid = 2'b01;
        step();
        reqValid = '0;
        #1;
        chk("preRstAwValid", 32'(awValid), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midRstAwValid", 32'(awValid), 0);
        chk("midRstWValid", 32'(wValid), 0);
        chk("midRstBusy", 32'(busy), 0);
        chk("midRstBReady", 32'(bReady), 0);
        step();
        chk("heldRstBusy", 32'(busy), 0);
        rst_ni = 1'b1;
        mPtr = 0;
        mErrDom = 0;

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < N; k++) begin
                cfg[k].Addr = $urandom;
                reqHart[k]  = HW'($urandom);
                reqEiid[k]  = ($urandom_range(0, 3) == 0) ? '0 : EW'($urandom);
            end
            reqValid = N'($urandom_range(0, 3));
            doTxn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, a, d, aw, e);
        end
        reqValid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aplic_domain_msi_arb.md
Name: aplic_domain_msi_arb

Overview:
- Shares one MSI write port (AXI-lite-style AW/W/B) among all APLIC interrupt domains running in MSI delivery mode.
- Each domain notifier raises a delivery request (target hart index, EIID).
- The block round-robin arbitrates, forms the MSI address from the granted domain's configured base Addr, issues one write, and waits for the response before the next grant.
- Sits between the per-domain notifiers and the system interconnect.

Parameters:
- NrDomains, 2, number of requesting domains (≤ NrDomainsMax in package).
- HartIdxW, 4, width of the target hart index.
- EiidW, 11, width of the external interrupt identity.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- domain_cfg_i  in  NrDomains x domain_cfg_t  static per-domain configuration; only .Addr is used
- req_valid_i  in  NrDomains  delivery request per domain
- req_ready_o  out  NrDomains  one-hot acceptance pulse
- req_hart_i  in  NrDomains x HartIdxW  target hart per domain
- req_eiid_i  in  NrDomains x EiidW  EIID per domain
- msi_aw_valid_o  out  1  address valid
- msi_aw_ready_i  in  1  address ready
- msi_aw_addr_o  out  32  MSI target address
- msi_w_valid_o  out  1  data valid
- msi_w_ready_i  in  1  data ready
- msi_w_data_o  out  32  MSI data = zero-extended EIID
- msi_b_valid_i  in  1  write response valid
- msi_b_ready_o  out  1  response ready
- msi_b_err_i  in  1  response not OKAY; qualified by msi_b_valid_i
- err_valid_o  out  1  one-cycle pulse on error response
- err_domain_o  out  $clog2(NrDomains)  domain of the failed write; holds its value until the next error
- busy_o  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values:
  - All valids, req_ready_o, msi_b_ready_o, err_valid_o, busy_o = 0.
  - Address/data/err_domain registers = 0.
  - Round-robin pointer = 0.
  - FSM = IDLE.
- FSM states: IDLE, SEND, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first requester at or after the rr pointer (wrapping).
  - Assert req_ready_o[g] combinationally in that cycle.
  - Capture addr = domain_cfg_i[g].Addr + (req_hart_i[g] << 12), truncated mod 2^32 (wrap-around is legal and not flagged).
  - Capture data = {zeros, req_eiid_i[g]} and the domain index g.
  - Set rr pointer to g+1 mod NrDomains.
  - If the EIID is 0: consume the request, stay in IDLE, issue no write. The pointer still advances.
  - Otherwise go to SEND.
- SEND:
  - msi_aw_valid_o and msi_w_valid_o are asserted from the first SEND cycle.
  - Each valid drops independently after its own handshake.
  - Address and data are stable while valid.
  - When both handshakes have completed (same cycle or different cycles), go to RESP.
- RESP:
  - msi_b_ready_o = 1.
  - On msi_b_valid_i, go to IDLE.
  - If msi_b_err_i is also set, pulse err_valid_o in the following cycle and latch err_domain_o.
  - Responses arriving outside RESP are ignored (msi_b_ready_o low).
- Latency: the grant cycle is IDLE; AW/W become valid the next cycle. With zero-wait slaves the minimum period is 3 cycles per delivered MSI.
- Only one outstanding write is ever in flight.
- Config changes after grant do not affect the in-flight write (captured values are used).
- Simultaneous requests from all domains are served strictly in rotation; no domain waits more than NrDomains grants.
- A requester dropping req_valid_i before grant is simply not served; no state is kept.
- Reset mid-operation forces IDLE immediately. Any handshake in progress is abandoned and valids drop asynchronously.

Decomposition:
- aplic_domain_pkg gains:
  - NrDomainsMax
  - msi_arb_state_e (IDLE/SEND/RESP)
  - msi_req_t {addr[31:0], data[31:0], dom}
  - MsiHartStride = 12
- Sub-module aplic_rr_arbiter (parameter N): request vector plus pointer in, one-hot grant and index out. It is purely combinational; the pointer register is kept in the parent.

Test Plan:
- Domain 0: Addr=0x2400_0000, hart 3, EIID 5 → AW addr 0x2400_3000 and W data 0x5, both valid the cycle after req_ready_o[0], with b OKAY and no error.
- Both domains requesting continuously → grants alternate 0,1,0,1, with exactly one req_ready_o pulse per transaction.
- aw_ready held low 4 cycles while w_ready=1 → W handshakes first and drops; AW stays valid with a stable address until its handshake; FSM enters RESP only after both.
- EIID 0 request → req_ready_o pulses, no AW/W activity, FSM stays IDLE, pointer advances.
- Addr=0xFFFF_F000, hart 1 → address wraps to 0x0000_0000 and is issued normally.
- B response with msi_b_err_i=1 for domain 1 → err_valid_o pulses 1 cycle, err_domain_o=1; rst_ni asserted during SEND → all valids 0 and busy_o=0 while reset is asserted.
